// File: rtl/data_path.sv
// data_path: single-bus CPU datapath with sixteen GPRs, PC/IR/MAR/MDR, HI/LO, Y, 64-bit Z and RB
// sharing one 32-bit bus and one ALU.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic [15:0] ALUControl,
  input  logic [31:0] Rin,
  input  logic [31:0] Rout,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        RZout,
  input  logic        RYin,
  input  logic        RBin,
  input  logic        PCjump,
  input  logic        MDRread,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRq,
  output logic [31:0] PCq,
  output logic [31:0] MARq
);
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, zlo_q, zhi_q, pc_q, mdr_q, rb_q, ir_q, mar_q, y_q;
  logic [31:0] src [23];
  logic [22:0] sel;
  logic [31:0] b;
  logic [4:0]  s;
  logic [63:0] yy, yr, yl, prod, z_d;
  logic        unused_bits;
  assign unused_bits = ^{Rin[31:23], Rin[18], Rout[31:23]};
  always_comb begin
    for (int i = 0; i < 16; i++) src[i] = r_q[i];
    src[16] = hi_q;
    src[17] = lo_q;
    src[18] = '0;
    src[19] = zlo_q;
    src[20] = pc_q;
    src[21] = mdr_q;
    src[22] = rb_q;
  end
  // Bit 18 has no source; scanning downward leaves the lowest asserted select on the bus.
  assign sel = Rout[22:0] & 23'h7BFFFF;
  always_comb begin
    b = RZout ? zhi_q : '0;
    for (int i = 22; i >= 0; i--) if (sel[i]) b = src[i];
  end
  assign BusMuxOut = b;
  assign s = b[4:0];
  assign yy = {y_q, y_q};
  assign yr = yy >> s;
  assign yl = yy << s;
  assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{b[31]}}, b});
  always_comb begin
    z_d = '0;
    case (ALUControl)
      16'd0:   z_d[31:0] = b + 32'd1;
      16'd1:   z_d[31:0] = y_q & b;
      16'd2:   z_d[31:0] = y_q | b;
      16'd3:   z_d[31:0] = y_q + b;
      16'd4:   z_d[31:0] = y_q - b;
      16'd5:   z_d[31:0] = -b;
      16'd6:   z_d[31:0] = ~b;
      16'd7:   z_d[31:0] = y_q >> s;
      16'd8:   z_d[31:0] = $signed(y_q) >>> s;
      16'd9:   z_d[31:0] = y_q << s;
      16'd10:  z_d[31:0] = yr[31:0];
      16'd11:  z_d[31:0] = yl[63:32];
      16'd12:  z_d = prod;
      16'd13:  z_d = (b == '0) ? '0 : {32'($signed(y_q) % $signed(b)), 32'($signed(y_q) / $signed(b))};
      default: z_d[31:0] = b;
    endcase
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      {hi_q, lo_q, zlo_q, zhi_q, pc_q} <= '0;
      {mdr_q, rb_q, ir_q, mar_q, y_q} <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (Rin[i]) r_q[i] <= b;
      if (Rin[16]) hi_q <= b;
      if (Rin[17]) lo_q <= b;
      if (Rin[19]) {zhi_q, zlo_q} <= z_d;
      if (PCjump) pc_q <= pc_q + b;
      else if (Rin[20]) pc_q <= b;
      if (Rin[21]) mdr_q <= MDRread ? Mdatain : b;
      if (Rin[22] || RBin) rb_q <= b;
      if (IRin) ir_q <= b;
      if (MARin) mar_q <= b;
      if (RYin) y_q <= b;
    end
  end
  assign IRq = ir_q;
  assign PCq = pc_q;
  assign MARq = mar_q;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed plus randomized bus-transfer sequences checked against a
// register-level behavioural model of the datapath.
module tb_data_path;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] Mdatain, Rin, Rout;
  logic [15:0] ALUControl;
  logic        IRin, MARin, RZout, RYin, RBin, PCjump, MDRread;
  logic [31:0] BusMuxOut, IRq, PCq, MARq;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_zl, m_zh, m_pc, m_mdr, m_rb, m_ir, m_mar, m_y;

  data_path dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .ALUControl(ALUControl),
    .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RZout(RZout),
    .RYin(RYin), .RBin(RBin), .PCjump(PCjump), .MDRread(MDRread),
    .BusMuxOut(BusMuxOut), .IRq(IRq), .PCq(PCq), .MARq(MARq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Mdatain = '0; Rin = '0; Rout = '0; ALUControl = '0;
    IRin = 0; MARin = 0; RZout = 0; RYin = 0; RBin = 0; PCjump = 0; MDRread = 0;
  endtask

  task automatic mreset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_hi, m_lo, m_zl, m_zh, m_pc, m_mdr, m_rb, m_ir, m_mar, m_y} = '0;
  endtask

  function automatic logic [31:0] msrc(input int i);
    if (i < 16) return m_r[i];
    case (i)
      16: return m_hi;
      17: return m_lo;
      19: return m_zl;
      20: return m_pc;
      21: return m_mdr;
      default: return m_rb;
    endcase
  endfunction

  function automatic logic [31:0] mbus();
    for (int i = 0; i < 23; i++) if (i != 18 && Rout[i]) return msrc(i);
    return RZout ? m_zh : 32'h0;
  endfunction

  function automatic logic [63:0] alu(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo, hi;
    int ia, ib, sh;
    longint p;
    ia = a; ib = b; sh = int'(b[4:0]); hi = '0;
    case (op)
      0: lo = b + 1;
      1: lo = a & b;
      2: lo = a | b;
      3: lo = a + b;
      4: lo = a - b;
      5: lo = 32'h0 - b;
      6: lo = ~b;
      7: lo = a >> sh;
      8: lo = $signed(a) >>> sh;
      9: lo = a << sh;
      10: lo = (a >> sh) | (a << (32 - sh));
      11: lo = (a << sh) | (a >> (32 - sh));
      12: begin p = longint'(ia) * longint'(ib); {hi, lo} = p; end
      13: if (ib == 0) lo = '0; else begin lo = ia / ib; hi = ia % ib; end
      default: lo = b;
    endcase
    return {hi, lo};
  endfunction

  task automatic peek(input string tag, input logic [31:0] exp);
    #1 chk(tag, BusMuxOut, exp);
  endtask

  task automatic tick(input string tag);
    logic [31:0] eb;
    logic [63:0] z;
    eb = mbus();
    #1 chk({tag, "/bus"}, BusMuxOut, eb);
    @(posedge clock);
    z = alu(ALUControl, m_y, eb);
    for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = eb;
    if (Rin[16]) m_hi = eb;
    if (Rin[17]) m_lo = eb;
    if (Rin[19]) {m_zh, m_zl} = z;
    if (PCjump) m_pc = m_pc + eb;
    else if (Rin[20]) m_pc = eb;
    if (Rin[21]) m_mdr = MDRread ? Mdatain : eb;
    if (Rin[22] || RBin) m_rb = eb;
    if (IRin) m_ir = eb;
    if (MARin) m_mar = eb;
    if (RYin) m_y = eb;
    #1;
    chk({tag, "/pc"}, PCq, m_pc);
    chk({tag, "/ir"}, IRq, m_ir);
    chk({tag, "/mar"}, MARq, m_mar);
    @(negedge clock);
    idle();
  endtask

  task automatic mem2mdr(input logic [31:0] v);
    Mdatain = v; MDRread = 1; Rin = 32'(1) << 21;
    tick("mdr");
  endtask

  task automatic mdr2reg(input int k);
    Rout = 32'(1) << 21; Rin = 32'(1) << k;
    tick("mdr2r");
  endtask

  initial begin
    logic [31:0] va, vb;
    int ka, kb;
    idle();
    mreset();
    #1;
    chk("rst/bus", BusMuxOut, 32'h0);
    chk("rst/ir", IRq, 32'h0);
    chk("rst/pc", PCq, 32'h0);
    chk("rst/mar", MARq, 32'h0);
    @(negedge clock);
    clear = 0;
    mem2mdr(32'h34); mdr2reg(5);
    mem2mdr(32'h45); mdr2reg(6);
    mem2mdr(32'h67); mdr2reg(2);
    Rout = 32'(1) << 5; peek("r5", 32'h34); idle();
    Rout = 32'(1) << 6; peek("r6", 32'h45); idle();
    Rout = 32'(1) << 2; peek("r2", 32'h67); idle();
    Rout = 32'(1) << 20; MARin = 1; Rin = 32'(1) << 19; ALUControl = 0;
    tick("fetch1");
    chk("fetch/mar", MARq, 32'h0);
    Rout = 32'(1) << 19; Rin = 32'(1) << 20;
    tick("fetch2");
    chk("fetch/pc", PCq, 32'h1);
    mem2mdr(32'h112B0000);
    Rout = 32'(1) << 21; IRin = 1;
    tick("irload");
    chk("ir", IRq, 32'h112B0000);
    Rout = 32'(1) << 5; RYin = 1; tick("or/y");
    Rout = 32'(1) << 6; ALUControl = 2; Rin = 32'(1) << 19; tick("or/z");
    Rout = 32'(1) << 19; Rin = 32'(1) << 2; tick("or/r2");
    Rout = 32'(1) << 2; peek("or", 32'h75); idle();
    mem2mdr(32'hFFFFFFFF);
    Rout = 32'(1) << 21; RYin = 1; tick("mul/y");
    mem2mdr(32'h2);
    Rout = 32'(1) << 21; ALUControl = 12; Rin = 32'(1) << 19; tick("mul/z");
    Rout = 32'(1) << 19; peek("mul/lo", 32'hFFFFFFFE); idle();
    RZout = 1; peek("mul/hi", 32'hFFFFFFFF); idle();
    mem2mdr(32'h7);
    Rout = 32'(1) << 21; RYin = 1; tick("div/y");
    mem2mdr(32'h2);
    Rout = 32'(1) << 21; ALUControl = 13; Rin = 32'(1) << 19; tick("div/z");
    Rout = 32'(1) << 19; peek("div/lo", 32'h3); idle();
    RZout = 1; peek("div/hi", 32'h1); idle();
    mem2mdr(32'h0);
    Rout = 32'(1) << 21; ALUControl = 13; Rin = 32'(1) << 19; tick("div0/z");
    Rout = 32'(1) << 19; peek("div0/lo", 32'h0); idle();
    RZout = 1; peek("div0/hi", 32'h0); idle();
    Rout = (32'(1) << 5) | (32'(1) << 19); peek("prio", 32'h34); idle();
    mem2mdr(32'h4);
    Rout = 32'(1) << 21; Rin = 32'(1) << 20; tick("pc4");
    mem2mdr(32'h8);
    Rout = 32'(1) << 21; PCjump = 1; Rin = 32'(1) << 20; tick("jump");
    chk("jump/pc", PCq, 32'hC);
    Rout = 32'(1) << 20; MARin = 1; IRin = 1; Rin = 32'(1) << 20;
    #2 clear = 1;
    #1;
    chk("clr/pc", PCq, 32'h0);
    chk("clr/mar", MARq, 32'h0);
    chk("clr/ir", IRq, 32'h0);
    chk("clr/bus", BusMuxOut, 32'h0);
    @(posedge clock);
    #1;
    chk("clrhold/pc", PCq, 32'h0);
    chk("clrhold/mar", MARq, 32'h0);
    @(negedge clock);
    clear = 0;
    mreset();
    idle();
    for (int n = 0; n < 40; n++) begin
      va = $urandom; vb = $urandom;
      if ($urandom_range(0, 3) == 0) vb = 32'($urandom_range(0, 40));
      if (va == 32'h80000000) va = 32'h1;
      ka = $urandom_range(0, 15); kb = $urandom_range(0, 15);
      mem2mdr(va); mdr2reg(ka);
      mem2mdr(vb);
      Rout = 32'(1) << 21; Rin = 32'(1) << kb; RBin = $urandom_range(0, 1);
      Rin[16] = $urandom_range(0, 1); Rin[17] = $urandom_range(0, 1);
      tick("rnd/ld");
      Rout = 32'(1) << ka; RYin = 1; tick("rnd/y");
      Rout = 32'(1) << kb; ALUControl = 16'($urandom_range(0, 15)); Rin = 32'(1) << 19;
      MARin = $urandom_range(0, 1); PCjump = ($urandom_range(0, 4) == 0);
      tick("rnd/alu");
      Rout = 32'(1) << 19; tick("rnd/zlo");
      RZout = 1; tick("rnd/zhi");
      Rout = $urandom & 32'h007FFFFF; RZout = $urandom_range(0, 1); tick("rnd/mux");
      Rout = 32'(1) << 22; tick("rnd/rb");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_path.md
# data_path

Phase-1 single-bus CPU datapath: sixteen 32-bit general registers, PC, IR, MAR, MDR, HI/LO, Y, Z (64-bit) and auxiliary RB, all joined by one 32-bit bus multiplexer and one ALU. An external control unit, or a bench, sequences it purely through one-hot in/out strobes and an encoded ALU opcode. Memory is not modelled: MAR is an output, and read data arrives on `Mdatain`.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-high reset; zeroes every register.
- `Mdatain` in 32: memory read data into the MDR mux.
- `ALUControl` in 16: encoded ALU opcode (see Operation).
- `Rin` in 32: one-hot-ish load enables. Bits 0–15 R0–R15; 16 HI; 17 LO; 19 Z (ZLow and ZHigh both load from ALU); 20 PC; 21 MDR; 22 RB. Other bits are ignored.
- `Rout` in 32: bus source selects. Bits 0–15 R0–R15; 16 HI; 17 LO; 19 ZLow; 20 PC; 21 MDR; 22 RB. Other bits are ignored.
- `IRin` in 1: IR loads bus.
- `MARin` in 1: MAR loads bus.
- `RZout` in 1: ZHigh drives bus.
- `RYin` in 1: Y loads bus.
- `RBin` in 1: RB loads bus; equivalent to `Rin[22]`.
- `PCjump` in 1: relative jump, PC <= PC + bus.
- `MDRread` in 1: MDR input mux select. 1 selects `Mdatain`; 0 selects the bus.
- `BusMuxOut` out 32: current bus value.
- `IRq`, `PCq`, `MARq` out 32 each: register contents for observation.

## Operation
- Bus mux (combinational):
  - Source is the lowest-index asserted bit among `Rout[0..22]`.
  - `RZout` has lowest priority, below all `Rout` bits.
  - With no source selected, the bus is 0.
- Register load: on a rising edge, each register whose enable is high takes its input. Every register holds otherwise.
- MDR input:
  - `MDRread`=1: `Mdatain`.
  - `MDRread`=0: bus.
  - MDR loads only when `Rin[21]` is high.
- ALU operands: A = Y, B = bus. The result is 64-bit; Z takes it when `Rin[19]` is high. Non-MUL/DIV results set ZHigh = 0.
- Opcodes (`ALUControl` value); shift amount is B[4:0]:
  - 0: B+1 (PC increment)
  - 1: A AND B
  - 2: A OR B
  - 3: A+B
  - 4: A−B
  - 5: −B
  - 6: NOT B
  - 7: A logical shift right
  - 8: A arithmetic shift right
  - 9: A shift left
  - 10: rotate right
  - 11: rotate left
  - 12: signed A×B, full 64 bits into {ZHigh, ZLow}
  - 13: signed A÷B, quotient to ZLow, remainder to ZHigh
  - Other values: B
- Arithmetic is modulo 2^32, except MUL.
- Divide by zero: Z = 0.
- R0 is an ordinary storage register.
- PC priority on the same edge:
  - `PCjump` wins over `Rin[20]`.
  - PC+bus wraps modulo 2^32.

## Timing
- Every load takes effect at the first rising edge while its enable is high. The new value is visible on the bus in the same cycle it is selected.
- Minimum transfer is one cycle: source select + destination enable → destination updated at the edge.
- ALU path is one cycle: Y loaded in cycle n; bus B plus opcode plus `Rin[19]` in cycle n+1; Z valid after that edge.
- Simultaneous loads: one bus value may load several destinations in one cycle, e.g. PC→MAR and Z in the same cycle.
- `clear` assertion: all registers are 0 immediately, regardless of the clock, and stay 0 while `clear` is high. A load coinciding with `clear` is discarded.
- Reset values: `BusMuxOut`=0 (no source), `IRq`=`PCq`=`MARq`=0.

## Test plan
- Register load:
  - Stimulus: `Mdatain`=0x34, `MDRread`=1, `Rin[21]`=1 for one edge; then `Rout[21]`+`Rin[5]`.
  - Response: R5=0x34. Repeat for R6=0x45 and R2=0x67.
- Fetch:
  - Stimulus: PC=0; `Rout[20]`+`MARin`+`Rin[19]` with opcode 0, then `Rout[19]`+`Rin[20]`.
  - Response: MAR=0, PC=1.
- Instruction load:
  - Stimulus: `Mdatain`=0x112B0000 into MDR, then `Rout[21]`+`IRin`.
  - Response: `IRq`=0x112B0000.
- OR sequence:
  - Stimulus: `Rout[5]`+`RYin`; `Rout[6]`+opcode 2+`Rin[19]`; `Rout[19]`+`Rin[2]`.
  - Response: R2=0x75.
- MUL/DIV:
  - MUL, Y=0xFFFFFFFF, bus=2 → {ZHigh, ZLow}=0xFFFFFFFF_FFFFFFFE.
  - DIV, 7÷2 → ZLow=3, ZHigh=1.
  - DIV by 0 → Z=0.
- Reset and priority:
  - `clear` pulse mid-transfer → all observable values are 0 at once.
  - `Rout[5]` and `Rout[19]` both high → bus carries R5.
  - `PCjump`+`Rin[20]`, PC=4, bus=8 → PC=12.
